// File: rtl/fdtd_wt_arbiter.sv
// Round-robin arbiter/burst sequencer sharing one FDTD AXI4 write master among NUM_REQ engines.
// Optional perf counters (perf_bursts_o/perf_beats_o) are built when FDTD_WT_ARB_PERF_EN is defined.
module fdtd_wt_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 32
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  input  logic [NUM_REQ-1:0]                   req_i,
  input  logic [NUM_REQ*AXI4_ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_REQ*8-1:0]                 len_i,
  input  logic [NUM_REQ*AXI4_DATA_WIDTH-1:0]   data_i,
  output logic [NUM_REQ-1:0]                   gnt_o,
  output logic [NUM_REQ-1:0]                   beat_o,
  output logic                                 wt_req_o,
  output logic [AXI4_ADDR_WIDTH-1:0]           wt_word_addr_o,
  output logic [7:0]                           axi_lenth_o,
  output logic [AXI4_DATA_WIDTH-1:0]           wt_data_o,
  input  logic                                 wt_gnt_i,
  input  logic                                 wt_beat_i,
  output logic                                 busy_o,
`ifdef FDTD_WT_ARB_PERF_EN
  output logic [31:0]                          perf_bursts_o,
  output logic [31:0]                          perf_beats_o,
`endif
  output logic                                 err_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CW    = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE} state_t;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]             owner_q, owner_d;
  logic [AXI4_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]                   len_q, len_d;
  logic [7:0]                   beat_cnt_q, beat_cnt_d;
  logic                         err_q, err_d;
  logic [IDX_W-1:0]             win;
  logic                         win_found;
  logic [CW-1:0]                cand;
  logic [7:0]                   req_len;
  logic [7:0]                   cnt_now;
`ifdef FDTD_WT_ARB_PERF_EN
  logic [31:0]                  perf_bursts_q, perf_bursts_d;
  logic [31:0]                  perf_beats_q, perf_beats_d;
`endif

  // Search upward from rr_ptr with wrap; the first pending requester wins.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + CW'(i);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!win_found && req_i[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win       = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    req_len    = len_i[int'(win)*8 +: 8];
    cnt_now    = beat_cnt_q + {7'd0, wt_beat_i};
    gnt_o      = '0;
    beat_o     = '0;
    wt_req_o   = 1'b0;
    busy_o     = 1'b0;
`ifdef FDTD_WT_ARB_PERF_EN
    perf_bursts_d = perf_bursts_q;
    perf_beats_d  = perf_beats_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          owner_d    = win;
          addr_d     = addr_i[int'(win)*AXI4_ADDR_WIDTH +: AXI4_ADDR_WIDTH];
          // The writer issues len-1, so a zero length must become one beat.
          len_d      = (req_len == 8'd0) ? 8'd1 : req_len;
          beat_cnt_d = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wt_req_o        = 1'b1;
        busy_o          = 1'b1;
        beat_o[owner_q] = wt_beat_i;
        gnt_o[owner_q]  = wt_gnt_i;
        beat_cnt_d      = cnt_now;
`ifdef FDTD_WT_ARB_PERF_EN
        if (wt_beat_i) perf_beats_d = perf_beats_q + 32'd1;
        if (wt_gnt_i)  perf_bursts_d = perf_bursts_q + 32'd1;
`endif
        if (wt_gnt_i) begin
          if (cnt_now != len_q) err_d = 1'b1;
          rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
`ifdef FDTD_WT_ARB_PERF_EN
      perf_bursts_q <= '0;
      perf_beats_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
`ifdef FDTD_WT_ARB_PERF_EN
      perf_bursts_q <= perf_bursts_d;
      perf_beats_q  <= perf_beats_d;
`endif
    end
  end

  assign wt_word_addr_o = addr_q;
  assign axi_lenth_o    = len_q;
  assign wt_data_o      = data_i[int'(owner_q)*AXI4_DATA_WIDTH +: AXI4_DATA_WIDTH];
  assign err_o          = err_q;
`ifdef FDTD_WT_ARB_PERF_EN
  assign perf_bursts_o  = perf_bursts_q;
  assign perf_beats_o   = perf_beats_q;
`endif

endmodule

// File: tb/tb_fdtd_wt_arbiter.sv
// Scoreboard bench for fdtd_wt_arbiter: the bench plays requesters and the downstream writer.
module tb_fdtd_wt_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [N-1:0]    req_i;
  logic [N*AW-1:0] addr_i;
  logic [N*8-1:0]  len_i;
  logic [N*DW-1:0] data_i;
  logic [N-1:0]    gnt_o, beat_o;
  logic            wt_req_o, wt_gnt_i, wt_beat_i, busy_o, err_o;
  logic [AW-1:0]   wt_word_addr_o;
  logic [7:0]      axi_lenth_o;
  logic [DW-1:0]   wt_data_o;
`ifdef FDTD_WT_ARB_PERF_EN
  logic [31:0]     perf_bursts_o, perf_beats_o;
`endif

  fdtd_wt_arbiter #(.NUM_REQ(N), .AXI4_ADDR_WIDTH(AW), .AXI4_DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .req_i(req_i), .addr_i(addr_i), .len_i(len_i),
    .data_i(data_i), .gnt_o(gnt_o), .beat_o(beat_o), .wt_req_o(wt_req_o),
    .wt_word_addr_o(wt_word_addr_o), .axi_lenth_o(axi_lenth_o), .wt_data_o(wt_data_o),
    .wt_gnt_i(wt_gnt_i), .wt_beat_i(wt_beat_i), .busy_o(busy_o),
`ifdef FDTD_WT_ARB_PERF_EN
    .perf_bursts_o(perf_bursts_o), .perf_beats_o(perf_beats_o),
`endif
    .err_o(err_o));

  always #5 ACLK = ~ACLK;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic [7:0]  len;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int failures = 0;

  // Observations captured by the writer driver for one burst.
  int          s_cyc, s_pulses;
  bit          s_to;
  logic [31:0] s_addr, s_data;
  logic [7:0]  s_len;
  logic        s_busy, s_rel_req, s_rel_busy;
  logic [N-1:0] s_bor, s_gnt;

  function automatic logic [31:0] data_of(int k);
    return 32'hD000_0000 + 32'(k);
  endfunction

  task automatic set_req(input int k, input logic [31:0] a, input logic [7:0] l);
    exp_t x;
    req_i[k]          = 1'b1;
    addr_i[k*AW +: AW] = a;
    len_i[k*8 +: 8]   = l;
    x.idx = k; x.addr = a; x.len = (l == 8'd0) ? 8'd1 : l;
    sb.push_back(x);
  endtask

  task automatic pop_exp();
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_empty: no expected burst queued");
      e.idx = 0; e.addr = '0; e.len = '0;
    end else e = sb.pop_front();
  endtask

  // Writer model: wait for wt_req_o, accept nbeats, optionally complete with wt_gnt_i.
  task automatic serve(input int nbeats, input bit do_gnt, input bit keep);
    s_cyc = 0; s_pulses = 0; s_bor = '0; s_gnt = '0; s_to = 1'b0;
    do begin
      @(posedge ACLK); #1;
      s_cyc++;
    end while (!wt_req_o && s_cyc < 50);
    s_to   = !wt_req_o;
    s_addr = wt_word_addr_o; s_len = axi_lenth_o; s_data = wt_data_o; s_busy = busy_o;
    for (int b = 0; b < nbeats; b++) begin
      wt_beat_i = 1'b1; #1;
      s_bor |= beat_o;
      if (beat_o != '0) s_pulses++;
      @(posedge ACLK); #1;
      wt_beat_i = 1'b0;
    end
    if (do_gnt) begin
      wt_gnt_i = 1'b1; #1;
      s_gnt = gnt_o;
      @(posedge ACLK); #1;
      wt_gnt_i = 1'b0;
      if (!keep) req_i = req_i & ~s_gnt;
      s_rel_req = wt_req_o; s_rel_busy = busy_o;
    end
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1; req_i = '0; addr_i = '0; len_i = '0; wt_gnt_i = 0; wt_beat_i = 0;
    for (int k = 0; k < N; k++) data_i[k*DW +: DW] = data_of(k);
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    checks++; if ({wt_req_o, busy_o, err_o} !== 3'b000) begin failures++;
      $display("FAIL reset_ctl: req/busy/err=%b required 000", {wt_req_o, busy_o, err_o}); end
    checks++; if ({gnt_o, beat_o} !== '0) begin failures++;
      $display("FAIL reset_pulses: gnt=%b beat=%b required 0", gnt_o, beat_o); end
    checks++; if (wt_word_addr_o !== '0 || axi_lenth_o !== '0) begin failures++;
      $display("FAIL reset_latch: addr=%h len=%0d required 0", wt_word_addr_o, axi_lenth_o); end
    checks++; if (wt_data_o !== data_of(0)) begin failures++;
      $display("FAIL reset_data: got %h required %h", wt_data_o, data_of(0)); end
`ifdef FDTD_WT_ARB_PERF_EN
    checks++; if (perf_bursts_o !== 0 || perf_beats_o !== 0) begin failures++;
      $display("FAIL reset_perf: bursts=%0d beats=%0d required 0", perf_bursts_o, perf_beats_o); end
`endif
  endtask

  task automatic test_single();
    set_req(1, 32'h0000_1000, 8'd4);
    serve(4, 1'b1, 1'b0);
    pop_exp();
    checks++; if (s_to || s_cyc !== 1) begin failures++;
      $display("FAIL single_latency: cycles=%0d required 1", s_cyc); end
    checks++; if (s_addr !== e.addr || s_len !== e.len) begin failures++;
      $display("FAIL single_latch: addr=%h len=%0d required %h %0d", s_addr, s_len, e.addr, e.len); end
    checks++; if (s_busy !== 1'b1 || s_data !== data_of(e.idx)) begin failures++;
      $display("FAIL single_busy_data: busy=%b data=%h required 1 %h", s_busy, s_data, data_of(e.idx)); end
    checks++; if (s_bor !== 4'b0010 || s_pulses !== 4) begin failures++;
      $display("FAIL single_beats: beat=%b pulses=%0d required 0010 4", s_bor, s_pulses); end
    checks++; if (s_gnt !== 4'b0010) begin failures++;
      $display("FAIL single_gnt: got %b required 0010", s_gnt); end
    checks++; if (s_rel_req !== 1'b0 || s_rel_busy !== 1'b0 || err_o !== 1'b0) begin failures++;
      $display("FAIL single_release: req=%b busy=%b err=%b required 0 0 0", s_rel_req, s_rel_busy, err_o); end
  endtask

  task automatic test_round_robin();
    exp_t x;
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 32'h0000_2000 + 32'(k * 16), 8'd1);
    x.idx = 0; x.addr = 32'h0000_2000; x.len = 8'd1;
    sb.push_back(x);
    for (int n = 0; n < 5; n++) begin
      serve(1, 1'b1, 1'b1);
      pop_exp();
      checks++; if (s_gnt !== 4'(1 << e.idx) || s_addr !== e.addr) begin failures++;
        $display("FAIL rr_order[%0d]: gnt=%b addr=%h required %b %h", n, s_gnt, s_addr, 4'(1 << e.idx), e.addr); end
      checks++; if (s_data !== data_of(e.idx)) begin failures++;
        $display("FAIL rr_data[%0d]: got %h required %h", n, s_data, data_of(e.idx)); end
      if (n > 0) begin
        checks++; if (s_to || s_cyc !== 2) begin failures++;
          $display("FAIL rr_gap[%0d]: cycles after release=%0d required 2", n, s_cyc); end
      end
    end
    req_i = '0;
  endtask

  task automatic test_simultaneous();
    set_req(2, 32'h0000_3000, 8'd1);
    serve(1, 1'b1, 1'b0);
    pop_exp();
    checks++; if (s_gnt !== 4'b0100) begin failures++;
      $display("FAIL simul_pre: gnt=%b required 0100", s_gnt); end
    set_req(3, 32'h0000_3300, 8'd2);
    set_req(0, 32'h0000_3000, 8'd2);
    for (int n = 0; n < 2; n++) begin
      serve(2, 1'b1, 1'b0);
      pop_exp();
      checks++; if (s_gnt !== 4'(1 << e.idx) || s_len !== e.len || s_addr !== e.addr) begin failures++;
        $display("FAIL simul[%0d]: gnt=%b len=%0d addr=%h required %b %0d %h", n, s_gnt, s_len, s_addr,
                 4'(1 << e.idx), e.len, e.addr); end
    end
  endtask

  task automatic test_len_zero();
    set_req(2, 32'h0000_4000, 8'd0);
    serve(1, 1'b1, 1'b0);
    pop_exp();
    checks++; if (s_len !== 8'd1 || s_gnt !== 4'b0100) begin failures++;
      $display("FAIL len0: len=%0d gnt=%b required 1 0100", s_len, s_gnt); end
    checks++; if (err_o !== 1'b0) begin failures++;
      $display("FAIL len0_err: err=%b required 0", err_o); end
    @(posedge ACLK); #1;
    wt_beat_i = 1'b1; wt_gnt_i = 1'b1; #1;
    checks++; if (beat_o !== '0 || gnt_o !== '0) begin failures++;
      $display("FAIL idle_stray: beat=%b gnt=%b required 0 0", beat_o, gnt_o); end
    @(posedge ACLK); #1;
    wt_beat_i = 1'b0; wt_gnt_i = 1'b0;
    checks++; if (err_o !== 1'b0 || wt_req_o !== 1'b0) begin failures++;
      $display("FAIL idle_stray_err: err=%b req=%b required 0 0", err_o, wt_req_o); end
  endtask

  task automatic test_len_mismatch();
    set_req(1, 32'h0000_5000, 8'd3);
    serve(2, 1'b1, 1'b0);
    pop_exp();
    checks++; if (err_o !== 1'b1) begin failures++;
      $display("FAIL mismatch_err: err=%b required 1", err_o); end
    set_req(0, 32'h0000_5100, 8'd2);
    serve(2, 1'b1, 1'b0);
    pop_exp();
    checks++; if (err_o !== 1'b1 || s_gnt !== 4'b0001) begin failures++;
      $display("FAIL mismatch_sticky: err=%b gnt=%b required 1 0001", err_o, s_gnt); end
    do_reset();
    checks++; if (err_o !== 1'b0) begin failures++;
      $display("FAIL mismatch_clear: err=%b required 0", err_o); end
  endtask

  task automatic test_reset_mid();
    set_req(2, 32'h0000_6000, 8'd1);
    serve(1, 1'b1, 1'b0);
    pop_exp();
    set_req(3, 32'h0000_6300, 8'd8);
    serve(2, 1'b0, 1'b0);
    pop_exp();
    checks++; if (s_bor !== 4'b1000 || s_len !== 8'd8) begin failures++;
      $display("FAIL mid_prefix: beat=%b len=%0d required 1000 8", s_bor, s_len); end
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    checks++; if (wt_req_o !== 1'b0 || busy_o !== 1'b0) begin failures++;
      $display("FAIL mid_reset: req=%b busy=%b required 0 0", wt_req_o, busy_o); end
`ifdef FDTD_WT_ARB_PERF_EN
    checks++; if (perf_bursts_o !== 0 || perf_beats_o !== 0) begin failures++;
      $display("FAIL mid_perf: bursts=%0d beats=%0d required 0", perf_bursts_o, perf_beats_o); end
`endif
    ARESET = 1'b0;
    req_i = '0;
    set_req(3, 32'h0000_6300, 8'd1);
    set_req(0, 32'h0000_6000, 8'd1);
    void'(sb.pop_front());
    serve(1, 1'b1, 1'b0);
    pop_exp();
    checks++; if (s_gnt !== 4'b0001) begin failures++;
      $display("FAIL mid_rrptr: gnt=%b required 0001", s_gnt); end
    req_i = '0;
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_simultaneous();
    test_len_zero();
    test_len_mismatch();
    test_reset_mid();
    repeat (2) @(posedge ACLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
